// File: rtl/tmr_ctl_if.sv
// Bus bundle between the timer controller, its host (cfg_*) and the timer it drives (tmr_*).
interface tmr_ctl_if;
    logic        cfg_stb;
    logic        cfg_we;
    logic [3:2]  cfg_addr;
    logic [31:0] cfg_din;
    logic [31:0] cfg_dout;
    logic        cfg_ack;
    logic        tmr_stb;
    logic        tmr_we;
    logic [3:2]  tmr_addr;
    logic [31:0] tmr_dout;
    logic [31:0] tmr_din;
    logic        tmr_ack;
    logic        tmr_irq;

    // Controller view: register slave towards the host, bus master towards the timer.
    modport slave (
        input  cfg_stb, cfg_we, cfg_addr, cfg_din,
        output cfg_dout, cfg_ack,
        output tmr_stb, tmr_we, tmr_addr, tmr_dout,
        input  tmr_din, tmr_ack, tmr_irq
    );

    modport master (
        output cfg_stb, cfg_we, cfg_addr, cfg_din,
        input  cfg_dout, cfg_ack,
        input  tmr_stb, tmr_we, tmr_addr, tmr_dout,
        output tmr_din, tmr_ack, tmr_irq
    );
endinterface

// File: rtl/tmr_ctl.sv
// Autonomous timer controller: programs the timer, services its interrupts, counts ticks
// and raises a match interrupt when the tick count reaches a host-set value.
module tmr_ctl #(
    parameter int unsigned MIN_PERIOD = 2,
    parameter int unsigned PERIOD_RST = 32'hFFFFFFFF
) (
    input  logic      clk,
    input  logic      rst,
    tmr_ctl_if.slave  bus,
    output logic      irq
);
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, SERVICE, STOP} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   period_q, period_d;
    logic [DW-1:0]   ticks_q, ticks_d;
    logic [DW-1:0]   match_q, match_d;
    logic            en_q, en_d, ien_q, ien_d;
    logic            mflag_q, mflag_d, reload_q, reload_d;
    logic            irq_q, irq_d;
    logic            tmr_stb_q, tmr_stb_d, tmr_we_q, tmr_we_d;
    logic [3:2]      tmr_addr_q, tmr_addr_d;
    logic [DW-1:0]   tmr_dout_q, tmr_dout_d;
    logic            host_wr, host_rd, period_wr, ticks_wr, ticks_upd;
    logic            unused_din;

    assign host_wr   = bus.cfg_stb & bus.cfg_we;
    assign host_rd   = bus.cfg_stb & ~bus.cfg_we;
    assign period_wr = host_wr && (bus.cfg_addr == 2'b01);
    assign ticks_wr  = host_wr && (bus.cfg_addr == 2'b10);
    assign unused_din = ^bus.tmr_din[DW-1:1];

    assign bus.cfg_ack  = bus.cfg_stb;
    assign bus.tmr_stb  = tmr_stb_q;
    assign bus.tmr_we   = tmr_we_q;
    assign bus.tmr_addr = tmr_addr_q;
    assign bus.tmr_dout = tmr_dout_q;
    assign irq          = irq_q;

    always_comb begin : cfg_read_mux
        unique case (bus.cfg_addr)
            2'b00:   bus.cfg_dout = {29'b0, mflag_q, ien_q, en_q};
            2'b01:   bus.cfg_dout = period_q;
            2'b10:   bus.cfg_dout = ticks_q;
            default: bus.cfg_dout = match_q;
        endcase
    end

    always_comb begin : next_state
        state_d   = state_q;
        period_d  = period_q;
        ticks_d   = ticks_q;
        match_d   = match_q;
        en_d      = en_q;
        ien_d     = ien_q;
        reload_d  = reload_q;
        mflag_d   = mflag_q;
        ticks_upd = 1'b0;

        if (host_wr) begin
            unique case (bus.cfg_addr)
                2'b00: begin
                    en_d  = bus.cfg_din[0];
                    ien_d = bus.cfg_din[1];
                end
                2'b01: begin
                    period_d = (bus.cfg_din < DW'(MIN_PERIOD)) ? DW'(MIN_PERIOD) : bus.cfg_din;
                    if (state_q != IDLE) reload_d = 1'b1;
                end
                2'b10: begin
                    ticks_d   = bus.cfg_din;
                    ticks_upd = 1'b1;
                end
                default: match_d = bus.cfg_din;
            endcase
        end

        unique case (state_q)
            IDLE: if (en_q) state_d = LOAD;
            LOAD: if (bus.tmr_ack) begin
                // A period write landing on the ack cycle must still force another reload.
                if (!period_wr) reload_d = 1'b0;
                state_d = ARM;
            end
            ARM: if (bus.tmr_ack) state_d = RUN;
            RUN: begin
                if (!en_q)            state_d = STOP;
                else if (reload_q)    state_d = LOAD;
                else if (bus.tmr_irq) state_d = SERVICE;
            end
            SERVICE: if (bus.tmr_ack) begin
                if (bus.tmr_din[0] && !ticks_wr) begin
                    ticks_d   = ticks_q + DW'(1);
                    ticks_upd = 1'b1;
                end
                state_d = RUN;
            end
            STOP: if (bus.tmr_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read-clear first so a coincident set wins.
        if (host_rd && (bus.cfg_addr == 2'b00)) mflag_d = 1'b0;
        if (ticks_upd && (ticks_d == match_q))  mflag_d = 1'b1;
        irq_d = ien_d & mflag_d;
    end

    always_comb begin : bus_outputs
        tmr_stb_d  = state_d inside {LOAD, ARM, SERVICE, STOP};
        tmr_we_d   = 1'b0;
        tmr_addr_d = 2'b00;
        tmr_dout_d = '0;
        unique case (state_d)
            LOAD: begin
                tmr_we_d   = 1'b1;
                tmr_addr_d = 2'b01;
                tmr_dout_d = (state_q == LOAD) ? tmr_dout_q : period_d;
            end
            ARM: begin
                tmr_we_d   = 1'b1;
                tmr_dout_d = DW'(2);
            end
            STOP:    tmr_we_d = 1'b1;
            default: tmr_we_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            period_q   <= DW'(PERIOD_RST);
            ticks_q    <= '0;
            match_q    <= '1;
            en_q       <= 1'b0;
            ien_q      <= 1'b0;
            mflag_q    <= 1'b0;
            reload_q   <= 1'b0;
            irq_q      <= 1'b0;
            tmr_stb_q  <= 1'b0;
            tmr_we_q   <= 1'b0;
            tmr_addr_q <= 2'b00;
            tmr_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            ticks_q    <= ticks_d;
            match_q    <= match_d;
            en_q       <= en_d;
            ien_q      <= ien_d;
            mflag_q    <= mflag_d;
            reload_q   <= reload_d;
            irq_q      <= irq_d;
            tmr_stb_q  <= tmr_stb_d;
            tmr_we_q   <= tmr_we_d;
            tmr_addr_q <= tmr_addr_d;
            tmr_dout_q <= tmr_dout_d;
        end
    end
endmodule

// File: tb/tb_tmr_ctl.sv
// Directed bench for tmr_ctl with a small behavioural timer on the tmr_* bus.
module tb_tmr_ctl;
    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    tmr_ctl_if bus();

    tmr_ctl #(.MIN_PERIOD(2), .PERIOD_RST(32'hFFFFFFFF)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: expires every t_div cycles while ien; expiry beats a coincident read-clear.
    logic [31:0] t_div, t_cnt;
    logic        t_ien, t_exp, t_expire;
    assign t_expire    = t_ien && (t_cnt == t_div - 32'd1);
    assign bus.tmr_ack = bus.tmr_stb;
    assign bus.tmr_irq = t_exp & t_ien;
    assign bus.tmr_din = (bus.tmr_addr == 2'b01) ? t_div : {30'b0, t_ien, t_exp};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_div <= '0; t_cnt <= '0; t_ien <= 1'b0; t_exp <= 1'b0;
        end else begin
            t_cnt <= t_expire ? 32'd0 : (t_ien ? t_cnt + 32'd1 : t_cnt);
            if (bus.tmr_stb && bus.tmr_we && bus.tmr_addr == 2'b01) t_div <= bus.tmr_dout;
            if (bus.tmr_stb && bus.tmr_we && bus.tmr_addr == 2'b00) begin
                t_ien <= bus.tmr_dout[1]; t_cnt <= '0; t_exp <= 1'b0;
            end else if (t_expire) t_exp <= 1'b1;
            else if (bus.tmr_stb && !bus.tmr_we && bus.tmr_addr == 2'b00) t_exp <= 1'b0;
        end
    end

    // Log of timer-bus writes and ctrl reads with their edge numbers.
    logic [1:0]  wa[$];
    logic [31:0] wd[$];
    int          wt[$];
    int          rt[$];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa.delete(); wd.delete(); wt.delete(); rt.delete();
        end else if (bus.tmr_stb && bus.tmr_ack) begin
            if (bus.tmr_we) begin
                wa.push_back(bus.tmr_addr); wd.push_back(bus.tmr_dout); wt.push_back(cyc);
            end else if (bus.tmr_addr == 2'b00) rt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_stb = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_din = d;
        @(negedge clk);
        bus.cfg_stb = 1'b0; bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        bus.cfg_stb = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = a;
        #1;
        d = bus.cfg_dout;
        @(negedge clk);
        bus.cfg_stb = 1'b0;
    endtask

    logic [31:0] rd;
    int n0, a_t, r1, r2, cnt;

    initial begin
        rst = 1'b0;
        bus.cfg_stb = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = 2'b00; bus.cfg_din = '0;
        tick(2);
        check("rst_stb", 32'(bus.tmr_stb), 0);
        check("rst_we", 32'(bus.tmr_we), 0);
        check("rst_addr", 32'(bus.tmr_addr), 0);
        check("rst_dout", bus.tmr_dout, 0);
        check("rst_irq", 32'(irq), 0);
        rst = 1'b1;
        tick(1);
        cfg_read(2'b00, rd); check("rst_ctrl", rd, 0);
        cfg_read(2'b01, rd); check("rst_period", rd, 32'hFFFFFFFF);
        cfg_read(2'b10, rd); check("rst_ticks", rd, 0);
        cfg_read(2'b11, rd); check("rst_match", rd, 32'hFFFFFFFF);

        // Period 10: divisor write, ctrl arm, three expiries serviced.
        do_reset();
        cfg_write(2'b01, 32'd10);
        cfg_write(2'b00, 32'd1);
        tick(38);
        check("t1_nwr", 32'(wa.size() >= 2), 1);
        if (wa.size() >= 2) begin
            check("t1_w0a", 32'(wa[0]), 1); check("t1_w0d", wd[0], 10);
            check("t1_w1a", 32'(wa[1]), 0); check("t1_w1d", wd[1], 2);
        end
        cfg_read(2'b10, rd); check("t1_ticks", rd, 3);
        check("t1_reads", 32'(rt.size()), 3);

        // Match interrupt at ticks==2, cleared by ctrl read.
        do_reset();
        cfg_write(2'b11, 32'd2);
        cfg_write(2'b01, 32'd8);
        cfg_write(2'b00, 32'd3);
        tick(15);
        check("t2_irq_lo", 32'(irq), 0);
        tick(9);
        check("t2_irq_hi", 32'(irq), 1);
        cfg_read(2'b00, rd); check("t2_ctrl7", rd, 32'h7);
        check("t2_irq_clr", 32'(irq), 0);
        cfg_read(2'b10, rd); check("t2_ticks", rd, 2);
        cfg_read(2'b00, rd); check("t2_ctrl3", rd, 32'h3);

        // Period below minimum clamps to 2; back-to-back expiries all counted.
        do_reset();
        cfg_write(2'b01, 32'd1);
        cfg_read(2'b01, rd); check("t3_clamp", rd, 2);
        cfg_write(2'b00, 32'd1);
        tick(46);
        cfg_read(2'b10, rd); check("t3_ticks", rd, 20);

        // Period change while running reloads divisor then re-arms.
        n0 = wd.size();
        cfg_write(2'b01, 32'd50);
        cnt = 0;
        while (wd.size() < n0 + 2 && cnt < 30) begin tick(1); cnt++; end
        check("t4_reload_seen", 32'(wd.size() >= n0 + 2), 1);
        if (wd.size() >= n0 + 2) begin
            check("t4_div_a", 32'(wa[n0]), 1); check("t4_div_d", wd[n0], 50);
            check("t4_arm_a", 32'(wa[n0+1]), 0); check("t4_arm_d", wd[n0+1], 2);
            a_t = wt[n0+1];
            cnt = 0; r1 = -1; r2 = -1;
            while (r2 < 0 && cnt < 200) begin
                tick(1); cnt++;
                r1 = -1; r2 = -1;
                foreach (rt[i]) begin
                    if (rt[i] > a_t && r1 < 0) r1 = rt[i];
                    else if (rt[i] > a_t && r2 < 0) r2 = rt[i];
                end
            end
            check("t4_two_svc", 32'(r2 >= 0), 1);
            if (r2 >= 0) begin
                check("t4_first_gap", 32'(r1 - a_t), 52);
                check("t4_period_gap", 32'(r2 - r1), 50);
            end
        end

        // Tick wrap to 0 hits match=0.
        do_reset();
        cfg_write(2'b11, 32'd0);
        cfg_write(2'b10, 32'hFFFFFFFF);
        cfg_write(2'b01, 32'd10);
        cfg_write(2'b00, 32'd3);
        tick(16);
        check("t5_irq", 32'(irq), 1);
        cfg_read(2'b10, rd); check("t5_ticks0", rd, 0);
        cfg_read(2'b00, rd); check("t5_ctrl7", rd, 32'h7);
        cfg_write(2'b11, 32'd5);
        cfg_write(2'b10, 32'd5);
        cfg_read(2'b00, rd); check("t5_hostmatch", rd, 32'h7);

        // Disable during SERVICE, then reset during LOAD.
        do_reset();
        cfg_write(2'b01, 32'd10);
        cfg_write(2'b00, 32'd1);
        tick(14);
        check("t6_in_svc", {bus.tmr_stb, bus.tmr_we}, 32'b10);
        cfg_write(2'b00, 32'd0);
        cfg_read(2'b10, rd); check("t6_ticks", rd, 1);
        check("t6_stop", {bus.tmr_stb, bus.tmr_we, bus.tmr_addr}, 32'b1100);
        check("t6_stop_dout", bus.tmr_dout, 0);
        tick(1);
        check("t6_idle", 32'(bus.tmr_stb), 0);
        check("t6_last_wd", (wd.size() > 0) ? wd[wd.size()-1] : 32'hDEAD, 0);
        cfg_write(2'b00, 32'd1);
        tick(1);
        check("t6_load", {bus.tmr_stb, bus.tmr_we, bus.tmr_addr}, 32'b1101);
        check("t6_load_d", bus.tmr_dout, 10);
        rst = 1'b0;
        #1;
        check("t6_rst_stb", 32'(bus.tmr_stb), 0);
        check("t6_rst_dout", bus.tmr_dout, 0);
        check("t6_rst_irq", 32'(irq), 0);
        cfg_read(2'b00, rd); check("t6_rst_ctrl", rd, 0);
        cfg_read(2'b01, rd); check("t6_rst_period", rd, 32'hFFFFFFFF);
        cfg_read(2'b10, rd); check("t6_rst_ticks", rd, 0);
        cfg_read(2'b11, rd); check("t6_rst_match", rd, 32'hFFFFFFFF);
        rst = 1'b1;
        tick(3);
        check("t6_post_idle", 32'(bus.tmr_stb), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
